// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display blocks.
//  - scan_state_t : slot state encoding (ST_BLANK, ST_SCAN)
//  - SEG_BLANK    : active-low "all segments off" pattern
//  - ANODE_OFF    : active-low "all anodes off" pattern, sliced to the digit count by the user
//  - seg_decode   : hex nibble -> active-low {g,f,e,d,c,b,a}
package seven_seg_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Widest digit count any display block may use; blocks slice ANODE_OFF down.
    localparam int MAX_DIGITS = 32;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = {MAX_DIGITS{1'b1}};

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle between a data producer and the scan controller, including the pins
// the controller drives towards the display.
//  load         : 1-cycle strobe capturing digit_data/digit_enable
//  digit_data   : nibble per digit, digit i = [4i+3:4i]
//  digit_enable : 1 = digit lit
//  segments     : {g,f,e,d,c,b,a}, active-low
//  anode        : one-hot-low digit select
//  update_done  : 1-cycle pulse when pending data reaches the display
interface seven_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   digit_data;
    logic [N_DIGITS-1:0]     digit_enable;
    logic [6:0]              segments;
    logic [N_DIGITS-1:0]     anode;
    logic                    update_done;

    modport master (
        output load, digit_data, digit_enable,
        input  segments, anode, update_done
    );

    modport slave (
        input  load, digit_data, digit_enable,
        output segments, anode, update_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_decode.sv
// hex_to_seven_seg: purely combinational nibble -> active-low segment decoder.
//  nibble : 4-bit hex value
//  seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup shared with the other display blocks.
    always_comb begin
        seg = seg_decode(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexes N_DIGITS hex digits onto one shared
// active-low 7-segment bus, blanking between digits to avoid ghosting. New
// digit data is double-buffered and committed only at frame boundaries.
//  clk : system clock, rising edge
//  rst : asynchronous, active-high
//  bus : slave side of seven_seg_scan_ctrl_if (load/data/enable in,
//        segments/anode/update_done out, all outputs registered)
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[N_DIGITS-1:0];

    scan_state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic [N_DIGITS-1:0]     anode_r, anode_nxt_s;
    logic [6:0]              seg_r, seg_nxt_s;
    logic                    update_done_r;
    logic                    frame_end_s;
    logic                    commit_s;

    logic [4*N_DIGITS-1:0]   pending_data_r;
    logic [N_DIGITS-1:0]     pending_en_r;
    logic                    pending_flag_r;
    logic [4*N_DIGITS-1:0]   display_data_r;
    logic [N_DIGITS-1:0]     display_en_r;

    logic [3:0]              digit_nibble_s;
    logic [6:0]              digit_seg_s;
    logic [N_DIGITS-1:0]     anode_sel_s;

    // Select the nibble and anode strobe of the digit owning the current slot.
    always_comb begin
        digit_nibble_s = display_data_r[{idx_r, 2'b00} +: 4];
        anode_sel_s    = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_r);
    end

    hex_to_seven_seg u_decode (
        .nibble (digit_nibble_s),
        .seg    (digit_seg_s)
    );

    // Scan FSM next state plus the next registered display outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        idx_nxt_s   = idx_r;
        anode_nxt_s = anode_r;
        seg_nxt_s   = seg_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nxt_s = ST_SCAN;
                    // A dark digit keeps its slot timing but never drives the pins.
                    if (display_en_r[idx_r]) begin
                        anode_nxt_s = anode_sel_s;
                        seg_nxt_s   = digit_seg_s;
                    end else begin
                        anode_nxt_s = ANODE_ALL_OFF;
                        seg_nxt_s   = SEG_BLANK;
                    end
                end else begin
                    anode_nxt_s = ANODE_ALL_OFF;
                    seg_nxt_s   = SEG_BLANK;
                end
            end
            ST_SCAN: begin
                if (cnt_r == SLOT_LAST) begin
                    state_nxt_s = ST_BLANK;
                    cnt_nxt_s   = '0;
                    anode_nxt_s = ANODE_ALL_OFF;
                    seg_nxt_s   = SEG_BLANK;
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s   = '0;
                        frame_end_s = 1'b1;
                    end else begin
                        idx_nxt_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        frame_end_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            default: begin
                state_nxt_s = ST_BLANK;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
                anode_nxt_s = ANODE_ALL_OFF;
                seg_nxt_s   = SEG_BLANK;
            end
        endcase
        commit_s = frame_end_s & pending_flag_r;
    end

    // Scan state, slot counter, digit index and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_BLANK;
            cnt_r         <= '0;
            idx_r         <= '0;
            anode_r       <= ANODE_ALL_OFF;
            seg_r         <= SEG_BLANK;
            update_done_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            idx_r         <= idx_nxt_s;
            anode_r       <= anode_nxt_s;
            seg_r         <= seg_nxt_s;
            update_done_r <= commit_s;
        end
    end

    // Double buffer: load fills pending, frame boundary moves it to display.
    // Enables come out of reset all-lit so a freshly reset display shows zeros.
    // A load on the commit edge wins the flag, so its data stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_data_r <= '0;
            pending_en_r   <= '0;
            pending_flag_r <= 1'b0;
            display_data_r <= '0;
            display_en_r   <= {N_DIGITS{1'b1}};
        end else begin
            if (bus.load) begin
                pending_data_r <= bus.digit_data;
                pending_en_r   <= bus.digit_enable;
                pending_flag_r <= 1'b1;
            end else if (commit_s) begin
                pending_flag_r <= 1'b0;
            end else begin
                pending_flag_r <= pending_flag_r;
            end
            if (commit_s) begin
                display_data_r <= pending_data_r;
                display_en_r   <= pending_en_r;
            end else begin
                display_data_r <= display_data_r;
                display_en_r   <= display_en_r;
            end
        end
    end

    assign bus.anode       = anode_r;
    assign bus.segments    = seg_r;
    assign bus.update_done = update_done_r;

endmodule
